pci_fifo_arbiter: RTL

Parametrised PCI bus arbiter that grants the shared bus in strict request-arrival (FIFO) order across `NUM_REQ` masters. It replaces the fixed 8-master arbiter with these additions:
- fully synchronous request capture
- duplicate-request suppression and withdrawn-request skipping
- hidden (overlapped) arbitration during busy cycles
- grant timeout
- optional bus parking

It sits between the per-master `REQ#` lines and the `GNT#` lines, watching `FRAME#`/`IRDY#` on the bus.

---
 rtl/pci_arb_pkg.sv | 20 ++
 rtl/pci_arb_fifo.sv | 75 +++++++
 rtl/pci_fifo_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pci_arb_pkg.sv
// rtl/pci_arb_pkg.sv - shared types and default constants for the FIFO-order PCI arbiter
package pci_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ     = 8;
  localparam int DEF_GNT_TIMEOUT = 16;
  localparam int DEF_PARK_EN     = 1;
  localparam int DEF_PARK_ID     = 0;

  // Timer must be able to hold the timeout value itself so it can saturate there.
  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pci_arb_fifo.sv
// rtl/pci_arb_fifo.sv - circular order queue holding master indices in arrival order
module pci_arb_fifo
  import pci_arb_pkg::*;
#(
  parameter int DEPTH = DEF_NUM_REQ,
  parameter int WIDTH = $clog2(DEF_NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for storage, pointers and occupancy; a pop frees room for a same-cycle push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pci_fifo_arbiter.sv
// rtl/pci_fifo_arbiter.sv - PCI bus arbiter granting masters in request-arrival order
module pci_fifo_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int PARK_EN     = DEF_PARK_EN,
  parameter int PARK_ID     = DEF_PARK_ID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_n,
  input  logic               frame_n,
  input  logic               irdy_n,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_id,
  output logic [IDX_W:0]     q_count
);

  localparam int TMR_W = tmr_width(GNT_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(GNT_TIMEOUT);
  localparam logic [IDX_W-1:0] PARK_IDX  = IDX_W'(PARK_ID);
  localparam int CNT_W = $clog2(NUM_REQ) + 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TMR_W-1:0]   timer_inc;
  logic               frame_n_prev_q, frame_n_prev_d;

  logic [NUM_REQ-1:0] eligible;
  logic               push;
  logic [IDX_W-1:0]   push_id;
  logic               pop;
  logic [IDX_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_empty;
  logic               frame_fall;
  logic               bus_idle;
  logic               head_live;
  logic               parked;

  assign frame_n_prev_d = frame_n;
  assign frame_fall     = frame_n_prev_q & ~frame_n;
  assign bus_idle       = frame_n & irdy_n;
  assign head_live      = ~req_n[fifo_head];
  assign parked         = (state_q == ARB_IDLE) && gnt_valid_q;

  pci_arb_fifo #(
    .DEPTH (NUM_REQ),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_id),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  // Lowest-index requester not already queued and not currently holding a grant gets queued.
  always_comb begin
    eligible = ~req_n & ~pending_q;
    if (state_q == ARB_GRANT) begin
      eligible[owner_q] = 1'b0;
    end
    push    = 1'b0;
    push_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        push    = 1'b1;
        push_id = IDX_W'(i);
      end
    end
  end

  // Track which masters sit in the queue so each appears at most once.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[fifo_head] = 1'b0;
    end
    if (push) begin
      pending_d[push_id] = 1'b1;
    end
  end

  // Arbitration FSM: grant order, parking, hidden arbitration and grant timeout.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gnt_n_d   = gnt_n_q;
    gnt_id_d  = gnt_id_q;
    timer_d   = timer_q;
    pop       = 1'b0;
    timer_inc = (timer_q == TMR_LIMIT) ? timer_q : timer_q + TMR_W'(1);

    case (state_q)
      ARB_IDLE: begin
        if (parked && frame_fall) begin
          // The parked master started a transaction on its own.
          state_d = ARB_BUSY;
          owner_d = PARK_IDX;
          gnt_n_d = '1;
        end else if (parked && !fifo_empty) begin
          // Release the park for one cycle before granting anyone.
          gnt_n_d = '1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head_live) begin
            gnt_n_d            = '1;
            gnt_n_d[fifo_head] = 1'b0;
            gnt_id_d           = fifo_head;
            owner_d            = fifo_head;
            timer_d            = '0;
            state_d            = ARB_GRANT;
          end
        end else if (PARK_EN != 0) begin
          gnt_n_d           = '1;
          gnt_n_d[PARK_IDX] = 1'b0;
          gnt_id_d          = PARK_IDX;
        end
      end

      ARB_GRANT: begin
        if (frame_fall) begin
          state_d = ARB_BUSY;
          gnt_n_d = '1;
        end else if (bus_idle) begin
          if (timer_inc == TMR_LIMIT) begin
            gnt_n_d = '1;
            timer_d = '0;
            state_d = ARB_IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
      end

      ARB_BUSY: begin
        if (!fifo_empty) begin
          // Hidden arbitration: hand the next grant out while the bus is still in use.
          pop = 1'b1;
          if (head_live) begin
            gnt_n_d            = '1;
            gnt_n_d[fifo_head] = 1'b0;
            gnt_id_d           = fifo_head;
            owner_d            = fifo_head;
            timer_d            = '0;
            state_d            = ARB_GRANT;
          end
        end else if (bus_idle) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
        gnt_n_d = '1;
      end
    endcase

    gnt_valid_d = ~&gnt_n_d;
  end

  // State, grant and timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      owner_q        <= '0;
      gnt_n_q        <= '1;
      gnt_valid_q    <= 1'b0;
      gnt_id_q       <= '0;
      pending_q      <= '0;
      timer_q        <= '0;
      frame_n_prev_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      gnt_n_q        <= gnt_n_d;
      gnt_valid_q    <= gnt_valid_d;
      gnt_id_q       <= gnt_id_d;
      pending_q      <= pending_d;
      timer_q        <= timer_d;
      frame_n_prev_q <= frame_n_prev_d;
    end
  end

  assign gnt_n     = gnt_n_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign q_count   = (IDX_W + 1)'(fifo_cnt);

endmodule
